// File: rtl/snake_step_scheduler.sv
// snake_step_scheduler
// Paces snake movement: divides CLK into move ticks, latches the player's
// direction with a no-reversal rule, issues one MOVE_REQ/MOVE_ACK handshake
// per step and shortens the step period each time food is eaten.
module snake_step_scheduler #(
    parameter int unsigned TICK_DIV   = 10_000_000,
    parameter int unsigned SPEED_STEP = 500_000,
    parameter int unsigned MIN_DIV    = 2_000_000,
    parameter int unsigned CNT_W      = 27
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  MASTER_STATE,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        FOOD_EATEN,
    input  logic        MOVE_ACK,
    output logic        MOVE_REQ,
    output logic [1:0]  DIRECTION,
    output logic [15:0] STEP_COUNT
);

    // Scheduler states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    // Master game-state encodings (11 behaves as WIN)
    localparam logic [1:0] MS_IDLE = 2'b00;
    localparam logic [1:0] MS_PLAY = 2'b01;

    // Direction encodings
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Period constants; the speed-up arithmetic runs one bit wider than the
    // counter so that the subtraction exposes a borrow instead of wrapping.
    localparam logic [CNT_W-1:0] L_TICK   = CNT_W'(TICK_DIV);
    localparam logic [CNT_W-1:0] L_MIN    = CNT_W'(MIN_DIV);
    localparam logic [CNT_W:0]   L_MIN_X  = (CNT_W+1)'(MIN_DIV);
    localparam logic [CNT_W:0]   L_STEP_X = (CNT_W+1)'(SPEED_STEP);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [1:0]       r_dir;
    logic [1:0]       r_pend;
    logic             r_req;
    logic [15:0]      r_step_count;

    logic             w_ms_play;
    logic             w_ms_idle;
    logic [1:0]       w_leave_state;
    logic             w_active;
    logic [CNT_W-1:0] w_period_m1;
    logic             w_tick;
    logic             w_wait_fire;
    logic             w_ack;
    logic             w_btn_any;
    logic [1:0]       w_cand;
    logic             w_cand_ok;
    logic [CNT_W:0]   w_sub_x;
    logic             w_above_floor;
    logic [CNT_W-1:0] w_food_period;

    assign w_ms_play     = (MASTER_STATE == MS_PLAY);
    assign w_ms_idle     = (MASTER_STATE == MS_IDLE);
    assign w_leave_state = w_ms_play ? S_WAIT : (w_ms_idle ? S_IDLE : S_HALT);
    assign w_active      = (r_state == S_WAIT) || (r_state == S_REQ);

    // ">=" rather than "==" so a period shortened below the running count
    // fires on the very next cycle instead of wrapping around.
    assign w_period_m1   = r_period - CNT_W'(1);
    assign w_tick        = (r_cnt >= w_period_m1);
    assign w_wait_fire   = (r_state == S_WAIT) && w_ms_play && w_tick;
    assign w_ack         = (r_state == S_REQ) && MOVE_ACK;

    // A borrow in the top bit means SPEED_STEP exceeded the current period.
    assign w_sub_x       = {1'b0, r_period} - L_STEP_X;
    assign w_above_floor = !w_sub_x[CNT_W] && (w_sub_x >= L_MIN_X);
    assign w_food_period = w_above_floor ? w_sub_x[CNT_W-1:0] : L_MIN;

    assign w_btn_any     = BTNU | BTND | BTNL | BTNR;
    assign w_cand_ok     = w_btn_any && (w_cand != (r_dir ^ 2'b10));

    // Button priority encoder: U > D > L > R
    always_comb begin
        w_cand = DIR_RIGHT;
        if (BTNU) begin
            w_cand = DIR_UP;
        end else if (BTND) begin
            w_cand = DIR_DOWN;
        end else if (BTNL) begin
            w_cand = DIR_LEFT;
        end
    end

    // Scheduler FSM and the MOVE_REQ handshake register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req <= 1'b0;
                    if (w_ms_play) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_ms_play) begin
                        r_state <= w_leave_state;
                    end else if (w_tick) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (MOVE_ACK) begin
                        r_req   <= 1'b0;
                        r_state <= w_leave_state;
                    end
                end
                S_HALT: begin
                    if (w_ms_idle) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Step divider: counts only while waiting in PLAY, otherwise held at zero
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && w_ms_play && !w_tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Step period: restored on IDLE, shortened by each food pulse during play
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_period <= L_TICK;
        end else if (r_state == S_IDLE) begin
            r_period <= L_TICK;
        end else if (w_active && FOOD_EATEN) begin
            r_period <= w_food_period;
        end
    end

    // Pending direction capture and commit at the start of each request
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_dir  <= DIR_RIGHT;
            r_pend <= DIR_RIGHT;
        end else if (r_state == S_IDLE) begin
            r_dir  <= DIR_RIGHT;
            r_pend <= DIR_RIGHT;
        end else if (w_active) begin
            if (w_cand_ok) begin
                r_pend <= w_cand;
            end
            if (w_wait_fire) begin
                r_dir <= r_pend;
            end
        end
    end

    // Saturating count of acknowledged steps
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_step_count <= '0;
        end else if (r_state == S_IDLE) begin
            r_step_count <= '0;
        end else if (w_ack && (r_step_count != '1)) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    assign MOVE_REQ   = r_req;
    assign DIRECTION  = r_dir;
    assign STEP_COUNT = r_step_count;

endmodule
